// File: rtl/audio_pwm_out_if.sv
// audio_pwm_out_if
// Bundles the sample/control inputs and the DAC/status outputs of the audio
// PWM output stage.
//   master : drives enable, sample_in, sample_strobe, volume, clear_flags;
//            observes pwm_out, frame_start, underrun, overrun
//   slave  : the output stage itself (mirror of master)
interface audio_pwm_out_if #(
  parameter int WAVE_BITS = 8,
  parameter int VOL_BITS  = 3
);
  logic                 enable;
  logic [WAVE_BITS-1:0] sample_in;
  logic                 sample_strobe;
  logic [VOL_BITS-1:0]  volume;
  logic                 clear_flags;
  logic                 pwm_out;
  logic                 frame_start;
  logic                 underrun;
  logic                 overrun;

  modport master (
    output enable, sample_in, sample_strobe, volume, clear_flags,
    input  pwm_out, frame_start, underrun, overrun
  );

  modport slave (
    input  enable, sample_in, sample_strobe, volume, clear_flags,
    output pwm_out, frame_start, underrun, overrun
  );
endinterface

// File: rtl/audio_pwm_out.sv
// audio_pwm_out
// Audio output stage behind the synth filter core. Captures a signed sample
// into a pending buffer, and at each frame boundary attenuates it by volume
// (arithmetic shift), converts to offset-binary duty and drives a one-pin
// PWM DAC. Sticky underrun/overrun report buffer starvation/overwrite.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high reset
//   bus    : audio_pwm_out_if.slave (enable, sample_in, sample_strobe, volume,
//            clear_flags in; pwm_out, frame_start, underrun, overrun out)
// Build option:
//   AUDIO_PWM_DSM_EN : pwm_out becomes a first-order delta-sigma bitstream
//                      with ones-density duty/2^PWM_BITS instead of PWM.
module audio_pwm_out #(
  parameter int WAVE_BITS = 8,
  parameter int PWM_BITS  = 8,
  parameter int VOL_BITS  = 3
) (
  input  logic            clk,
  input  logic            reset,
  audio_pwm_out_if.slave  bus
);
  localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;
  localparam logic [PWM_BITS-1:0] DUTY_MID = {1'b1, {(PWM_BITS-1){1'b0}}};

  logic [PWM_BITS-1:0]         cnt;
  logic [PWM_BITS-1:0]         duty;
  logic [PWM_BITS-1:0]         duty_load;
  logic [WAVE_BITS-1:0]        pending;
  logic                        pending_full;
  logic                        wrap;
  logic                        underrun_set;
  logic                        overrun_set;
  logic                        pwm_next;
  logic signed [WAVE_BITS-1:0] scaled;
  logic [WAVE_BITS-1:0]        offset;
  logic                        pwm_q;
  logic                        frame_start_q;
  logic                        underrun_q;
  logic                        overrun_q;

  assign wrap = bus.enable && (cnt == CNT_MAX);

  // Volume is applied at load time, so a volume change affects the next frame.
  assign scaled = $signed(pending) >>> bus.volume;
  assign offset = {~scaled[WAVE_BITS-1], scaled[WAVE_BITS-2:0]};

  generate
    if (PWM_BITS > WAVE_BITS) begin : g_pad
      assign duty_load = {offset, {(PWM_BITS-WAVE_BITS){1'b0}}};
    end else if (PWM_BITS == WAVE_BITS) begin : g_same
      assign duty_load = offset;
    end else begin : g_trunc
      assign duty_load = offset[WAVE_BITS-1 -: PWM_BITS];
    end
  endgenerate

  // A strobe landing on the load cycle is a hand-off, not an overwrite.
  assign underrun_set = wrap && !pending_full;
  assign overrun_set  = bus.sample_strobe && pending_full && !wrap;

`ifdef AUDIO_PWM_DSM_EN
  logic [PWM_BITS:0] acc;
  logic [PWM_BITS:0] acc_sum;

  assign acc_sum  = {1'b0, acc[PWM_BITS-1:0]} + {1'b0, duty};
  assign pwm_next = bus.enable && acc_sum[PWM_BITS];

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (bus.enable) begin
      acc <= acc_sum;
    end
  end
`else
  assign pwm_next = bus.enable && (cnt < duty);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      duty          <= DUTY_MID;
      pending       <= '0;
      pending_full  <= 1'b0;
      pwm_q         <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      if (bus.enable) begin
        cnt <= cnt + 1'b1;
      end
      if (wrap && pending_full) begin
        duty <= duty_load;
      end
      if (bus.sample_strobe) begin
        pending      <= bus.sample_in;
        pending_full <= 1'b1;
      end else if (wrap) begin
        pending_full <= 1'b0;
      end
      pwm_q         <= pwm_next;
      frame_start_q <= wrap;
      underrun_q    <= (underrun_q && !bus.clear_flags) || underrun_set;
      overrun_q     <= (overrun_q && !bus.clear_flags) || overrun_set;
    end
  end

  assign bus.pwm_out     = pwm_q;
  assign bus.frame_start = frame_start_q;
  assign bus.underrun    = underrun_q;
  assign bus.overrun     = overrun_q;
endmodule
